busg_arb: RTL and testbench

BUSG_ARB -- requirements
Module: busg_arb

---
 rtl/busg_arb.sv | 145 ++++++++++++++
 tb/tb_busg_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/busg_arb.sv
// busg_arb: round-robin arbiter and strobe sequencer for the shared G bus.
// Three requesters compete for one 8-bit data bus. The winner's byte is
// latched at grant, and the owner's strobe is framed by one setup cycle and
// HOLD hold cycles. A one-cycle ack marks completion.
module busg_arb #(
  parameter int PULSE = 3,  // strobe-high length in cycles, 1..15
  parameter int HOLD  = 1   // data-hold cycles after strobe falls, 0..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic [2:0] ack,
  output logic [7:0] g,
  output logic [2:0] gc,
  output logic       busy,
  output logic [1:0] owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  localparam logic [3:0] PULSE_LD = 4'(PULSE - 1);
  localparam logic [3:0] HOLD_LD  = (HOLD > 0) ? 4'(HOLD - 1) : 4'd0;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;

  logic [2:0] elig;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [1:0] start;
  logic [2:0] cand;

  logic [2:0] ack_n;
  logic [7:0] g_n;
  logic [2:0] gc_n;
  logic       busy_n;
  logic [1:0] owner_n;

  // Round-robin pick: search from owner+1 (mod 3). A requester acked this
  // cycle is masked so it cannot win twice in a row.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    elig      = req & ~ack;
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    start     = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
    cand      = 3'd0;
    for (int i = 0; i < 3; i++) begin
      cand = 3'(start) + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!gnt_valid && elig[cand[1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[1:0];
      end
    end
  end

  // State and phase counter register; reset wins over every transition.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: counter loads on phase entry and advances at zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE: begin
        if (gnt_valid) state_n = S_SETUP;
      end
      S_SETUP: begin
        state_n = S_STROBE;
        cnt_n   = PULSE_LD;
      end
      S_STROBE: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else if (HOLD == 0) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_HOLD;
          cnt_n   = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (cnt != 4'd0) cnt_n = cnt - 4'd1;
        else             state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, derived from the
  // upcoming state so each output lines up with the phase it describes.
  always_comb begin
    g_n     = g;
    owner_n = owner;
    if (state == S_IDLE && gnt_valid) begin
      owner_n = gnt_idx;
      unique case (gnt_idx)
        2'd0:    g_n = data0;
        2'd1:    g_n = data1;
        default: g_n = data2;
      endcase
    end
    gc_n   = (state_n == S_STROBE) ? (3'b001 << owner_n) : 3'b000;
    busy_n = (state_n != S_IDLE);
    ack_n  = (state != S_IDLE && state_n == S_IDLE) ? (3'b001 << owner) : 3'b000;
  end

  // Output registers; owner resets to 2 so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack   <= 3'b000;
      g     <= 8'h00;
      gc    <= 3'b000;
      busy  <= 1'b0;
      owner <= 2'd2;
    end else begin
      ack   <= ack_n;
      g     <= g_n;
      gc    <= gc_n;
      busy  <= busy_n;
      owner <= owner_n;
    end
  end

endmodule

// File: tb/tb_busg_arb.sv
// tb_busg_arb: scoreboard bench for busg_arb. Expected per-cycle outputs are
// built from the transaction timing (SETUP, PULSE strobe cycles, HOLD cycles,
// ack) and queued when stimulus is driven; each task pops and compares one
// entry per cycle. A second instance covers PULSE=1, HOLD=0.
module tb_busg_arb;

  typedef struct packed {
    logic [2:0] ack;
    logic [7:0] g;
    logic [2:0] gc;
    logic       busy;
    logic [1:0] owner;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst, rst_b;
  logic [2:0] req, req_b;
  logic [7:0] data0, data1, data2, d0_b, d1_b, d2_b;
  logic [2:0] ack, ack_b, gc, gc_b;
  logic [7:0] g, g_b;
  logic       busy, busy_b;
  logic [1:0] owner, owner_b;

  obs_t sb[$];
  obs_t exp_v, obs_v;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  busg_arb dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .ack(ack), .g(g), .gc(gc), .busy(busy), .owner(owner)
  );

  busg_arb #(.PULSE(1), .HOLD(0)) dut_short (
    .clk(clk), .rst(rst_b), .req(req_b),
    .data0(d0_b), .data1(d1_b), .data2(d2_b),
    .ack(ack_b), .g(g_b), .gc(gc_b), .busy(busy_b), .owner(owner_b)
  );

  function automatic obs_t mk(logic [2:0] a, logic [7:0] d, logic [2:0] s,
                              logic b, logic [1:0] o);
    obs_t t;
    t.ack = a; t.g = d; t.gc = s; t.busy = b; t.owner = o;
    return t;
  endfunction

  function automatic string fmt(obs_t t);
    return $sformatf("ack=%b g=%h gc=%b busy=%b owner=%0d",
                     t.ack, t.g, t.gc, t.busy, t.owner);
  endfunction

  function automatic obs_t obs_a();
    return mk(ack, g, gc, busy, owner);
  endfunction

  function automatic obs_t obs_b();
    return mk(ack_b, g_b, gc_b, busy_b, owner_b);
  endfunction

  // Expected cycles 1 .. 2+p+h after a grant sample for requester r, byte d.
  function automatic void push_txn(int r, logic [7:0] d, int p, int h);
    logic [2:0] one;
    one = 3'b001 << r;
    sb.push_back(mk(3'b000, d, 3'b000, 1'b1, 2'(r)));
    for (int i = 0; i < p; i++) sb.push_back(mk(3'b000, d, one, 1'b1, 2'(r)));
    for (int i = 0; i < h; i++) sb.push_back(mk(3'b000, d, 3'b000, 1'b1, 2'(r)));
    sb.push_back(mk(one, d, 3'b000, 1'b0, 2'(r)));
  endfunction

  function automatic void push_idle(int r, logic [7:0] d);
    sb.push_back(mk(3'b000, d, 3'b000, 1'b0, 2'(r)));
  endfunction

  function automatic void push_rst();
    sb.push_back(mk(3'b000, 8'h00, 3'b000, 1'b0, 2'd2));
  endfunction

  // Reset held with all requests high: outputs must sit at reset values.
  task automatic test_reset();
    rst = 1'b1; req = 3'b111;
    data0 = 8'hFF; data1 = 8'hEE; data2 = 8'hDD;
    @(posedge clk); #1;
    for (int c = 1; c <= 3; c++) begin
      push_rst();
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = obs_a(); n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL reset c%0d: got %s want %s", c, fmt(obs_v), fmt(exp_v));
      end
    end
  endtask

  // Single write from requester 0, sampled on the first edge out of reset.
  task automatic test_single();
    rst = 1'b0; req = 3'b001; data0 = 8'hA5;
    push_txn(0, 8'hA5, 3, 1);
    push_idle(0, 8'hA5);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = obs_a(); n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL single c%0d: got %s want %s", c, fmt(obs_v), fmt(exp_v));
      end
      req = 3'b000;
    end
  endtask

  // All three requesting: grants 0,1,2 back to back, acks 6 cycles apart,
  // and the just-acked requester 2 is not regranted.
  task automatic test_back_to_back();
    rst = 1'b1; req = 3'b000;
    data0 = 8'h11; data1 = 8'h22; data2 = 8'h33;
    push_rst();
    push_txn(0, 8'h11, 3, 1);
    push_txn(1, 8'h22, 3, 1);
    push_txn(2, 8'h33, 3, 1);
    push_idle(2, 8'h33);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = obs_a(); n_vec++;
      if (obs_v !== exp_v || !$onehot0(gc)) begin
        n_err++;
        $display("FAIL back_to_back c%0d: got %s want %s", c, fmt(obs_v), fmt(exp_v));
      end
      if (c == 1) begin rst = 1'b0; req = 3'b111; end
      if (c == 8)  req[0] = 1'b0;
      if (c == 14) req[1] = 1'b0;
      if (c == 20) req[2] = 1'b0;
    end
  endtask

  // Requester 1 pulses req for one cycle; the transaction still completes.
  task automatic test_early_drop();
    req = 3'b010; data1 = 8'h77;
    push_txn(1, 8'h77, 3, 1);
    push_idle(1, 8'h77);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = obs_a(); n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL early_drop c%0d: got %s want %s", c, fmt(obs_v), fmt(exp_v));
      end
      req = 3'b000;
      data1 = 8'h00;
    end
  endtask

  // data0 toggles every cycle after grant; g keeps the value latched at grant.
  task automatic test_data_hold();
    req = 3'b001; data0 = 8'h5A;
    push_txn(0, 8'h5A, 3, 1);
    push_idle(0, 8'h5A);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = obs_a(); n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL data_hold c%0d: got %s want %s", c, fmt(obs_v), fmt(exp_v));
      end
      req = 3'b000;
      data0 = ~data0;
    end
  endtask

  // Reset in the second strobe cycle aborts without ack; the following
  // req=011 goes to requester 0 first.
  task automatic test_reset_mid();
    req = 3'b010; data1 = 8'h44; data0 = 8'h55;
    push_txn(1, 8'h44, 3, 1);
    for (int i = 0; i < 3; i++) void'(sb.pop_back());
    push_rst();
    push_txn(0, 8'h55, 3, 1);
    push_idle(0, 8'h55);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = obs_a(); n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid c%0d: got %s want %s", c, fmt(obs_v), fmt(exp_v));
      end
      case (c)
        1:       req = 3'b000;
        3:       rst = 1'b1;
        4:       begin rst = 1'b0; req = 3'b011; end
        default: req = 3'b000;
      endcase
    end
  endtask

  // PULSE=1, HOLD=0 instance: SETUP, one strobe cycle, then ack.
  task automatic test_short();
    push_rst();
    exp_v = sb.pop_front(); obs_v = obs_b(); n_vec++;
    if (obs_v !== exp_v) begin
      n_err++;
      $display("FAIL short_reset: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
    rst_b = 1'b0; req_b = 3'b100; d2_b = 8'hC3;
    push_txn(2, 8'hC3, 1, 0);
    push_idle(2, 8'hC3);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front(); obs_v = obs_b(); n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL short c%0d: got %s want %s", c, fmt(obs_v), fmt(exp_v));
      end
      req_b = 3'b000;
    end
  endtask

  initial begin
    rst_b = 1'b1; req_b = 3'b000;
    d0_b = 8'h00; d1_b = 8'h00; d2_b = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_early_drop();
    test_data_hold();
    test_reset_mid();
    test_short();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
